// File: rtl/router_pkg.sv
// Shared definitions for the 1x4 router packet controller: FSM state type and
// default port-count / address-width values used by router_fsm.
package router_pkg;

    localparam int ROUTER_NUM_PORTS = 4;
    localparam int ROUTER_ADDR_W    = 2;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        FIFO_FULL_STATE    = 3'd3,
        LOAD_AFTER_FULL    = 3'd4,
        LOAD_PARITY        = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } router_state_t;

endpackage

// File: rtl/router_wait_timer.sv
// Cycle counter for the WAIT_TILL_EMPTY state of router_fsm. Counts cycles
// spent in the waiting state and flags the terminal count, after which the
// controller gives up on the stalled destination.
module router_wait_timer #(
    parameter int TIMEOUT_CYCLES = 30
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic active,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] count_reg;

    // Count while waiting; any exit from the waiting state or a clear restarts at 0.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_reg <= '0;
        end else if (clear || !active) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign expired = active && (count_reg == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/router_fsm.sv
// Packet-level controller for the 1x4 router. Decodes the header address,
// sequences router_reg through header/payload/parity loading and full-hold,
// gates FIFO writes and drives busy back to the source.
// Optional build macro ROUTER_WAIT_TIMEOUT_EN: bounds the time spent in
// WAIT_TILL_EMPTY and pulses wait_timeout when the packet is abandoned.
module router_fsm
    import router_pkg::*;
#(
    parameter int NUM_PORTS      = ROUTER_NUM_PORTS,
    parameter int ADDR_W         = ROUTER_ADDR_W,
    parameter int TIMEOUT_CYCLES = 30
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 pkt_valid,
    input  logic [ADDR_W-1:0]    data_in,
    input  logic                 fifo_full,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic [NUM_PORTS-1:0] soft_reset,
    input  logic                 parity_done,
    input  logic                 low_packet_valid,
    output logic                 detect_add,
    output logic                 lfd_state,
    output logic                 ld_state,
    output logic                 laf_state,
    output logic                 full_state,
    output logic                 rst_int_reg,
    output logic                 write_enb_reg,
    output logic                 busy,
    output logic [ADDR_W-1:0]    dest_addr,
    output logic                 wait_timeout
);

    router_state_t     state_reg, state_next;
    logic [ADDR_W-1:0] dest_addr_reg, dest_addr_next;
    logic              addr_ok;
    logic              soft_hit;

    // Header addresses beyond the port count are dropped silently.
    assign addr_ok  = int'(data_in) < NUM_PORTS;
    // A read-timeout on the destination FIFO aborts the packet from any busy state.
    assign soft_hit = (state_reg != DECODE_ADDRESS) && soft_reset[dest_addr_reg];

`ifdef ROUTER_WAIT_TIMEOUT_EN
    logic timer_expired;
    logic timeout_fire;
    logic wait_timeout_reg;

    router_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (soft_hit),
        .active  (state_reg == WAIT_TILL_EMPTY),
        .expired (timer_expired)
    );

    assign wait_timeout = wait_timeout_reg;
`else
    assign wait_timeout = 1'b0;
`endif

    // State register, latched destination and (optionally) the timeout pulse.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg        <= DECODE_ADDRESS;
            dest_addr_reg    <= '0;
`ifdef ROUTER_WAIT_TIMEOUT_EN
            wait_timeout_reg <= 1'b0;
`endif
        end else begin
            state_reg        <= state_next;
            dest_addr_reg    <= dest_addr_next;
`ifdef ROUTER_WAIT_TIMEOUT_EN
            wait_timeout_reg <= timeout_fire;
`endif
        end
    end

    // Next-state logic plus Moore output decode from the current state.
    always_comb begin
        state_next     = state_reg;
        dest_addr_next = dest_addr_reg;
`ifdef ROUTER_WAIT_TIMEOUT_EN
        timeout_fire   = 1'b0;
`endif
        detect_add     = 1'b0;
        lfd_state      = 1'b0;
        ld_state       = 1'b0;
        laf_state      = 1'b0;
        full_state     = 1'b0;
        rst_int_reg    = 1'b0;
        write_enb_reg  = 1'b0;
        busy           = 1'b1;

        case (state_reg)
            DECODE_ADDRESS: begin
                detect_add = 1'b1;
                busy       = 1'b0;
                if (pkt_valid && addr_ok) begin
                    dest_addr_next = data_in;
                    state_next     = fifo_empty[data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
            end
            LOAD_FIRST_DATA: begin
                lfd_state  = 1'b1;
                state_next = LOAD_DATA;
            end
            LOAD_DATA: begin
                ld_state      = 1'b1;
                write_enb_reg = 1'b1;
                busy          = 1'b0;
                // A full FIFO must be serviced before the parity byte is taken.
                if (fifo_full) begin
                    state_next = FIFO_FULL_STATE;
                end else if (!pkt_valid) begin
                    state_next = LOAD_PARITY;
                end
            end
            FIFO_FULL_STATE: begin
                full_state = 1'b1;
                if (!fifo_full) begin
                    state_next = LOAD_AFTER_FULL;
                end
            end
            LOAD_AFTER_FULL: begin
                laf_state     = 1'b1;
                write_enb_reg = 1'b1;
                if (parity_done) begin
                    state_next = DECODE_ADDRESS;
                end else if (low_packet_valid) begin
                    state_next = LOAD_PARITY;
                end else begin
                    state_next = LOAD_DATA;
                end
            end
            LOAD_PARITY: begin
                write_enb_reg = 1'b1;
                state_next    = CHECK_PARITY_ERROR;
            end
            CHECK_PARITY_ERROR: begin
                rst_int_reg = 1'b1;
                state_next  = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            WAIT_TILL_EMPTY: begin
                if (fifo_empty[dest_addr_reg]) begin
                    state_next = LOAD_FIRST_DATA;
`ifdef ROUTER_WAIT_TIMEOUT_EN
                end else if (timer_expired) begin
                    state_next   = DECODE_ADDRESS;
                    timeout_fire = 1'b1;
`endif
                end
            end
            default: state_next = DECODE_ADDRESS;
        endcase

        if (soft_hit) begin
            state_next   = DECODE_ADDRESS;
`ifdef ROUTER_WAIT_TIMEOUT_EN
            timeout_fire = 1'b0;
`endif
        end
    end

    assign dest_addr = dest_addr_reg;

endmodule

// File: tb/tb_router_fsm.sv
// Directed bench for router_fsm: a packet-level reference model checked on every
// cycle, plus hand-computed expectations at the key points of each scenario.
module tb_router_fsm;

    localparam int NP = 4;
    localparam int AW = 2;
    localparam int TO = 30;

    // Reference model phases (bench-local numbering).
    localparam int P_DEC  = 0;
    localparam int P_LFD  = 1;
    localparam int P_LD   = 2;
    localparam int P_FULL = 3;
    localparam int P_LAF  = 4;
    localparam int P_LP   = 5;
    localparam int P_CPE  = 6;
    localparam int P_WAIT = 7;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          pkt_valid = 1'b0;
    logic [AW-1:0] data_in = '0;
    logic          fifo_full = 1'b0;
    logic [NP-1:0] fifo_empty = 4'hF;
    logic [NP-1:0] soft_reset = '0;
    logic          parity_done = 1'b0;
    logic          low_packet_valid = 1'b0;
    logic          detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
    logic          write_enb_reg, busy, wait_timeout;
    logic [AW-1:0] dest_addr;

    int checks = 0;
    int errors = 0;
    logic cmp_en = 1'b0;

    router_fsm #(.NUM_PORTS(NP), .ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .pkt_valid        (pkt_valid),
        .data_in          (data_in),
        .fifo_full        (fifo_full),
        .fifo_empty       (fifo_empty),
        .soft_reset       (soft_reset),
        .parity_done      (parity_done),
        .low_packet_valid (low_packet_valid),
        .detect_add       (detect_add),
        .lfd_state        (lfd_state),
        .ld_state         (ld_state),
        .laf_state        (laf_state),
        .full_state       (full_state),
        .rst_int_reg      (rst_int_reg),
        .write_enb_reg    (write_enb_reg),
        .busy             (busy),
        .dest_addr        (dest_addr),
        .wait_timeout     (wait_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int            m_phase = P_DEC;
    logic [AW-1:0] m_dest = '0;
    int            m_wcnt = 0;
    logic          m_wt = 1'b0;

    // Strobe vector {detect,lfd,ld,laf,full,rst_int,write_enb,busy} per phase.
    function automatic logic [7:0] m_outs(input int ph);
        case (ph)
            P_DEC:   return 8'b1000_0000;
            P_LFD:   return 8'b0100_0001;
            P_LD:    return 8'b0010_0010;
            P_FULL:  return 8'b0000_1001;
            P_LAF:   return 8'b0001_0011;
            P_LP:    return 8'b0000_0011;
            P_CPE:   return 8'b0000_0101;
            default: return 8'b0000_0001;
        endcase
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_phase = P_DEC;
            m_dest  = '0;
            m_wcnt  = 0;
            m_wt    = 1'b0;
        end else begin : step
            int nxt;
            nxt  = m_phase;
            m_wt = 1'b0;
            case (m_phase)
                P_DEC:
                    if (pkt_valid && int'(data_in) < NP) begin
                        m_dest = data_in;
                        nxt = fifo_empty[data_in] ? P_LFD : P_WAIT;
                    end
                P_LFD:  nxt = P_LD;
                P_LD:   if (fifo_full) nxt = P_FULL; else if (!pkt_valid) nxt = P_LP;
                P_FULL: if (!fifo_full) nxt = P_LAF;
                P_LAF:  nxt = parity_done ? P_DEC : (low_packet_valid ? P_LP : P_LD);
                P_LP:   nxt = P_CPE;
                P_CPE:  nxt = fifo_full ? P_FULL : P_DEC;
                default: begin
                    if (fifo_empty[m_dest]) nxt = P_LFD;
`ifdef ROUTER_WAIT_TIMEOUT_EN
                    else if (m_wcnt == TO - 1) begin
                        nxt  = P_DEC;
                        m_wt = 1'b1;
                    end
`endif
                end
            endcase
            if (m_phase != P_DEC && soft_reset[m_dest]) begin
                nxt  = P_DEC;
                m_wt = 1'b0;
            end
            if (m_phase == P_WAIT && nxt == P_WAIT) m_wcnt++;
            else m_wcnt = 0;
            m_phase = nxt;
        end
    end

    // Per-cycle comparison, sampled on the falling edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("strobes", {detect_add, lfd_state, ld_state, laf_state, full_state,
                              rst_int_reg, write_enb_reg, busy}, m_outs(m_phase));
            check("dest_addr", dest_addr, m_dest);
            check("wait_timeout", wait_timeout, m_wt);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] hdr;
        int we_cnt, ld_cnt, busy_ld;
        int waited, guard;

        // Reset state
        tick(); tick();
        cmp_en = 1'b1;
        check("rst_detect_add", detect_add, 1);
        check("rst_busy", busy, 0);
        check("rst_write_enb", write_enb_reg, 0);
        check("rst_dest_addr", dest_addr, 0);
        #2 resetn = 1'b1;
        tick();
        $display("reset released: detect_add=%0b", detect_add);

        // Packet 1: header 8'h22 (addr 2), 8 payloads, parity
        hdr = 8'h22;
        pkt_valid = 1'b1; data_in = hdr[AW-1:0]; fifo_empty = 4'hF;
        tick();
        check("p1_lfd", lfd_state, 1);
        check("p1_dest", dest_addr, 2);
        check("p1_lfd_busy", busy, 1);
        we_cnt = 0; ld_cnt = 0; busy_ld = 0;
        for (int i = 0; i < 9; i++) begin
            if (i == 8) pkt_valid = 1'b0;
            tick();
            we_cnt += int'(write_enb_reg);
            ld_cnt += int'(ld_state);
            if (ld_state && busy) busy_ld++;
        end
        check("p1_we_cycles", we_cnt, 9);
        check("p1_ld_cycles", ld_cnt, 8);
        check("p1_busy_in_ld", busy_ld, 0);
        tick();
        check("p1_cpe", rst_int_reg, 1);
        tick();
        check("p1_back_to_decode", detect_add, 1);
        $display("packet1 addr=2 writes=%0d ld=%0d", we_cnt, ld_cnt);

        // Packet 2: addr 1 with FIFO 1 not empty -> wait, then full handling
        pkt_valid = 1'b1; data_in = 2'd1; fifo_empty = 4'b1101;
        tick();
        check("p2_wait_busy", busy, 1);
        check("p2_wait_no_lfd", lfd_state, 0);
        repeat (4) tick();
        check("p2_still_wait", {detect_add, lfd_state, busy}, 3'b001);
        fifo_empty = 4'hF;
        tick();
        check("p2_lfd", lfd_state, 1);
        tick(); tick();
        check("p2_ld", ld_state, 1);
        fifo_full = 1'b1;
        tick();
        check("p2_full", full_state, 1);
        check("p2_full_we", write_enb_reg, 0);
        check("p2_full_busy", busy, 1);
        repeat (3) tick();
        check("p2_full_hold", full_state, 1);
        fifo_full = 1'b0;
        tick();
        check("p2_laf", {laf_state, write_enb_reg}, 2'b11);
        tick();
        check("p2_laf_to_ld", {ld_state, busy}, 2'b10);
        $display("packet2 addr=1 wait+full path done");

        // Variant: low_packet_valid at LAF, then CPE with full, parity_done at LAF
        fifo_full = 1'b1;
        tick();
        fifo_full = 1'b0;
        tick();
        low_packet_valid = 1'b1; pkt_valid = 1'b0;
        tick();
        check("v_lp", {ld_state, write_enb_reg, busy}, 3'b011);
        low_packet_valid = 1'b0;
        tick();
        check("v_cpe", rst_int_reg, 1);
        fifo_full = 1'b1;
        tick();
        check("v_cpe_full", full_state, 1);
        fifo_full = 1'b0;
        tick();
        parity_done = 1'b1;
        tick();
        check("v_parity_done", detect_add, 1);
        parity_done = 1'b0;
        $display("variant low_packet_valid/parity_done done");

        // Soft reset: ignored in DECODE, other ports ignored, own port aborts
        pkt_valid = 1'b1; data_in = 2'd3; soft_reset = 4'b1000;
        tick();
        check("sr_ignored_in_decode", lfd_state, 1);
        check("sr_dest", dest_addr, 3);
        soft_reset = 4'b0001;
        tick(); tick();
        check("sr_other_port", ld_state, 1);
        soft_reset = 4'b1000;
        tick();
        check("sr_abort", {detect_add, busy}, 2'b10);
        soft_reset = '0; pkt_valid = 1'b0;
        tick();
        check("sr_idle", detect_add, 1);
        $display("soft reset abort done");

        // Asynchronous reset mid-packet
        pkt_valid = 1'b1; data_in = 2'd2;
        tick(); tick();
        check("ar_ld", ld_state, 1);
        #2 resetn = 1'b0;
        #1;
        check("ar_detect", detect_add, 1);
        check("ar_dest", dest_addr, 0);
        check("ar_we", write_enb_reg, 0);
        pkt_valid = 1'b0;
        tick(); tick();
        #2 resetn = 1'b1;
        tick();
        check("ar_after", detect_add, 1);
        $display("async reset mid-packet done");

`ifdef ROUTER_WAIT_TIMEOUT_EN
        // Timeout out of WAIT_TILL_EMPTY
        pkt_valid = 1'b1; data_in = 2'd2; fifo_empty = 4'b1011;
        tick();
        pkt_valid = 1'b0;
        waited = 1; guard = 0;
        while (busy && guard < 100) begin
            tick();
            guard++;
            if (busy) waited++;
        end
        check("to_wait_cycles", waited, TO);
        check("to_pulse", wait_timeout, 1);
        check("to_decode", detect_add, 1);
        tick();
        check("to_pulse_end", wait_timeout, 0);
        fifo_empty = 4'hF;
        $display("wait timeout after %0d cycles", waited);
`endif

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/router_fsm.md
Name: router_fsm

Overview:
- Packet-level controller for the 1x4 router.
- Decodes the destination from the header byte and sequences the register block (header/payload/parity load, full-hold, parity check).
- Gates writes into the four output FIFOs and drives busy back to the source.
- Sits between the source interface, router_reg and the FIFO/synchroniser block.

Parameters:
- NUM_PORTS, 4, number of destination FIFOs.
- ADDR_W, 2, address field width (data_in[ADDR_W-1:0] of the header).
- TIMEOUT_CYCLES, 30, WAIT_TILL_EMPTY limit (used only with the optional feature).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- resetn  in  1  asynchronous active-low reset.
- pkt_valid  in  1  source asserts for header+payload, drops on the parity byte.
- data_in  in  ADDR_W  header address bits.
- fifo_full  in  1  full flag of the currently addressed FIFO.
- fifo_empty  in  NUM_PORTS  per-FIFO empty flags.
- soft_reset  in  NUM_PORTS  per-FIFO read-timeout resets from the synchroniser.
- parity_done  in  1  from router_reg: parity byte captured.
- low_packet_valid  in  1  from router_reg: pkt_valid fell while FIFO was full.
- detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg  out  1  state strobes to router_reg.
- write_enb_reg  out  1  FIFO write enable.
- busy  out  1  stall to source.
- dest_addr  out  ADDR_W  latched destination.
- wait_timeout  out  1  one-cycle drop pulse (optional feature only, else tied 0).

Behaviour:
- One-hot or binary Moore FSM, 8 states: DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY.
- Reset (async, resetn=0):
  - state=DECODE_ADDRESS, dest_addr=0.
  - detect_add=1, all other outputs 0.
- DECODE_ADDRESS:
  - Latch dest_addr<=data_in when pkt_valid=1 and data_in<NUM_PORTS.
  - With a valid address: fifo_empty[data_in]=1 -> LOAD_FIRST_DATA; else -> WAIT_TILL_EMPTY.
  - Address >= NUM_PORTS or pkt_valid=0 -> stay; packet is dropped, no write.
- LOAD_FIRST_DATA -> LOAD_DATA unconditionally (header written this cycle).
- LOAD_DATA:
  - fifo_full=1 -> FIFO_FULL_STATE. This has priority over pkt_valid=0.
  - Else pkt_valid=0 -> LOAD_PARITY.
  - Else stay.
- FIFO_FULL_STATE: fifo_full=0 -> LOAD_AFTER_FULL; else stay.
- LOAD_AFTER_FULL:
  - parity_done=1 -> DECODE_ADDRESS.
  - Else low_packet_valid=1 -> LOAD_PARITY.
  - Else -> LOAD_DATA.
- LOAD_PARITY -> CHECK_PARITY_ERROR.
- CHECK_PARITY_ERROR: fifo_full=1 -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
- WAIT_TILL_EMPTY: fifo_empty[dest_addr]=1 -> LOAD_FIRST_DATA; else stay.
- soft_reset[dest_addr]=1 in any state except DECODE_ADDRESS -> DECODE_ADDRESS next edge. This overrides all other transitions.
- Outputs are decoded from the current state only, giving one cycle latency from an input to its output change:
  - detect_add in DECODE_ADDRESS; lfd_state in LOAD_FIRST_DATA; ld_state in LOAD_DATA; laf_state in LOAD_AFTER_FULL; full_state in FIFO_FULL_STATE; rst_int_reg in CHECK_PARITY_ERROR.
  - write_enb_reg in LOAD_DATA, LOAD_PARITY, LOAD_AFTER_FULL.
  - busy=1 in all states except DECODE_ADDRESS and LOAD_DATA.
- Back-to-back packets: a header may be presented on the cycle state re-enters DECODE_ADDRESS.

Optional Feature:
- Macro ROUTER_WAIT_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to WAIT_TILL_EMPTY and increments each cycle there.
  - On reaching TIMEOUT_CYCLES-1 with fifo_empty[dest_addr]=0: go to DECODE_ADDRESS and pulse wait_timeout for 1 cycle.
  - The counter clears on async reset and on soft_reset.
- When undefined: no counter, WAIT_TILL_EMPTY waits indefinitely, wait_timeout tied 0.

Decomposition:
- router_pkg holds the state enum typedef (router_state_t), ADDR_W and NUM_PORTS defaults.
- One sub-module, router_wait_timer: counter plus terminal-count compare, instantiated only under ROUTER_WAIT_TIMEOUT_EN.

Test Plan:
- Reset, then header 8'h22 (addr 2) with fifo_empty=4'hF and 8 payloads, then parity -> states DECODE, LFD, LD x8, LP, CPE, DECODE; write_enb_reg high 9 cycles; busy low during LD.
- Header addr 1 with fifo_empty[1]=0 for 5 cycles -> WAIT_TILL_EMPTY with busy=1; when fifo_empty[1] rises -> LOAD_FIRST_DATA next edge.
- fifo_full=1 on the 3rd payload for 4 cycles -> FIFO_FULL_STATE, write_enb_reg=0, busy=1; then LAF -> LD.
- Variant: low_packet_valid=1 at LAF -> LOAD_PARITY.
- soft_reset[dest_addr] pulsed mid LOAD_DATA -> DECODE_ADDRESS next edge, detect_add=1; resetn=0 mid-packet -> immediate DECODE_ADDRESS.
- With ROUTER_WAIT_TIMEOUT_EN and TIMEOUT_CYCLES=30, fifo_empty held 0 -> wait_timeout pulses after 30 cycles in WAIT, FSM returns to DECODE.
